// File: rtl/lab3_q2.sv
// lab3_q2 -- clocked model of the gate Y = ~A & B with a fixed propagation delay.
//
// ~a & b is sampled into a DELAY-deep register pipeline, and y is the last
// stage. A zero-delay combinational copy, y_comb, is also provided. One-cycle
// edge pulses on y are produced, plus an optional counter of y rising edges.
//
// Parameters:
//   DELAY  clock edges from sampling a/b to y (1..16)
//   CNT_W  width of the y rising-edge counter
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   a, b    logic inputs (a is the inverted term)
//   y       delayed ~a & b, flop output
//   y_comb  combinational ~a & b, ignores rst
//   y_rise  one-cycle pulse on y 0->1
//   y_fall  one-cycle pulse on y 1->0
//   y_cnt   count of y rising edges, mod 2^CNT_W
//           (only when LAB3_Q2_RISE_COUNT_EN is defined)
module lab3_q2 #(
  parameter int DELAY = 2,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y,
  output logic y_comb,
  output logic y_rise,
  output logic y_fall
`ifdef LAB3_Q2_RISE_COUNT_EN
  ,
  output logic [CNT_W-1:0] y_cnt
`endif
);

  if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
    $error("lab3_q2: DELAY must be in 1..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("lab3_q2: CNT_W must be >= 1");
  end

  logic [DELAY-1:0] stage;
  logic             y_q;

  assign y_comb = ~a & b;

  // stage[0] captures the gate; each further stage adds one edge of delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= ~a & b;
      for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
    end
  end

  assign y = stage[DELAY-1];

  // y_q is cleared with the pipeline, so reset release never makes a pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= 1'b0;
    else     y_q <= y;
  end

  assign y_rise = y & ~y_q;
  assign y_fall = ~y & y_q;

`ifdef LAB3_Q2_RISE_COUNT_EN
  // the count reflects a rise in the cycle after the y_rise pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         y_cnt <= '0;
    else if (y_rise) y_cnt <= y_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_lab3_q2.sv
module tb_lab3_q2;

  logic clk = 1'b0;
  logic rst, a, b;
  logic [2:0] y, y_comb, y_rise, y_fall;
`ifdef LAB3_Q2_RISE_COUNT_EN
  logic [2:0][1:0] y_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference: history of sampled gate values, newest first
  logic q[$];
  logic ye[3], re[3], fe[3];
  int   cnt_e[3];

  always #5 clk = ~clk;

  lab3_q2 #(.DELAY(1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y[0]), .y_comb(y_comb[0]),
    .y_rise(y_rise[0]), .y_fall(y_fall[0])
`ifdef LAB3_Q2_RISE_COUNT_EN
    , .y_cnt(y_cnt[0])
`endif
  );
  lab3_q2 #(.DELAY(2), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y[1]), .y_comb(y_comb[1]),
    .y_rise(y_rise[1]), .y_fall(y_fall[1])
`ifdef LAB3_Q2_RISE_COUNT_EN
    , .y_cnt(y_cnt[1])
`endif
  );
  lab3_q2 #(.DELAY(5), .CNT_W(2)) u_d5 (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y[2]), .y_comb(y_comb[2]),
    .y_rise(y_rise[2]), .y_fall(y_fall[2])
`ifdef LAB3_Q2_RISE_COUNT_EN
    , .y_cnt(y_cnt[2])
`endif
  );

  function automatic int dly(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 3; k++) begin
      ye[k] = 1'b0; re[k] = 1'b0; fe[k] = 1'b0; cnt_e[k] = 0;
    end
  endtask

  // advance one clock; model updates from the values present at the edge
  task automatic step();
    logic s, sr, old;
    @(posedge clk);
    s  = ~a & b;
    sr = rst;
    #1;
    if (!sr) begin
      q.push_front(s);
      if (q.size() > 16) void'(q.pop_back());
      for (int k = 0; k < 3; k++) begin
        if (re[k]) cnt_e[k]++;
        old   = ye[k];
        ye[k] = (q.size() >= dly(k)) ? q[dly(k)-1] : 1'b0;
        re[k] = ye[k] & ~old;
        fe[k] = ~ye[k] & old;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b0; b = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (y !== 3'b000 || y_rise !== 3'b000 || y_fall !== 3'b000 || y_comb !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_init: y=%b rise=%b fall=%b comb=%b, want 000 000 000 111", y, y_rise, y_fall, y_comb);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (y[k] !== ye[k] || y_rise[k] !== re[k] || y_fall[k] !== fe[k]) begin
          n_fail++;
          $display("FAIL reset_run d%0d c%0d: y/r/f=%b%b%b want %b%b%b", dly(k), c, y[k], y_rise[k], y_fall[k], ye[k], re[k], fe[k]);
        end
      end
      // D=2: y rises with a pulse on the 2nd edge after release
      if (c == 1) begin
        n_tests++;
        if (y[1] !== 1'b1 || y_rise[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_release_d2: y=%b rise=%b want 1 1", y[1], y_rise[1]);
        end
      end
    end
    // mid-clock assertion clears immediately, y_comb unaffected
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (y !== 3'b000 || y_rise !== 3'b000 || y_fall !== 3'b000 || y_comb !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_async: y=%b rise=%b fall=%b comb=%b, want 000 000 000 111", y, y_rise, y_fall, y_comb);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (y[k] !== ye[k] || y_rise[k] !== re[k] || y_fall[k] !== fe[k]) begin
          n_fail++;
          $display("FAIL reset_rerun d%0d c%0d: y/r/f=%b%b%b want %b%b%b", dly(k), c, y[k], y_rise[k], y_fall[k], ye[k], re[k], fe[k]);
        end
      end
    end
  endtask

  task automatic test_truth_sweep();
    logic [1:0] pairs[4];
    int rises[3], falls[3], first_hi[3];
    pairs = '{2'b00, 2'b01, 2'b11, 2'b10};
    a = 1'b0; b = 1'b0;
    for (int c = 0; c < 8; c++) step();
    for (int k = 0; k < 3; k++) begin rises[k] = 0; falls[k] = 0; first_hi[k] = -1; end
    for (int p = 0; p < 4; p++) begin
      {a, b} = pairs[p];
      #1;
      n_tests++;
      if (y_comb !== {3{~a & b}}) begin
        n_fail++;
        $display("FAIL truth_comb a=%b b=%b: y_comb=%b want %b", a, b, y_comb, {3{~a & b}});
      end
      for (int c = 0; c < 10; c++) begin
        step();
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (y[k] !== ye[k] || y_rise[k] !== re[k] || y_fall[k] !== fe[k]) begin
            n_fail++;
            $display("FAIL truth d%0d ab=%b%b c%0d: y/r/f=%b%b%b want %b%b%b", dly(k), a, b, c, y[k], y_rise[k], y_fall[k], ye[k], re[k], fe[k]);
          end
          rises[k] += int'(y_rise[k]);
          falls[k] += int'(y_fall[k]);
          if (p == 1 && first_hi[k] < 0 && y[k] === 1'b1) first_hi[k] = c;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rises[k] != 1 || falls[k] != 1 || first_hi[k] != dly(k) - 1) begin
        n_fail++;
        $display("FAIL truth_summary d%0d: rises=%0d falls=%0d lag=%0d want 1 1 %0d", dly(k), rises[k], falls[k], first_hi[k], dly(k) - 1);
      end
    end
  endtask

  task automatic test_pulse();
    int hi[3], ri[3], fi[3];
    a = 1'b0; b = 1'b0;
    for (int c = 0; c < 8; c++) step();
    for (int k = 0; k < 3; k++) begin hi[k] = 0; ri[k] = -1; fi[k] = -1; end
    b = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      b = 1'b0;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (y[k] !== ye[k] || y_rise[k] !== re[k] || y_fall[k] !== fe[k]) begin
          n_fail++;
          $display("FAIL pulse d%0d c%0d: y/r/f=%b%b%b want %b%b%b", dly(k), c, y[k], y_rise[k], y_fall[k], ye[k], re[k], fe[k]);
        end
        hi[k] += int'(y[k]);
        if (y_rise[k] === 1'b1) ri[k] = c;
        if (y_fall[k] === 1'b1) fi[k] = c;
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (hi[k] != 1 || ri[k] != dly(k) - 1 || fi[k] != ri[k] + 1) begin
        n_fail++;
        $display("FAIL pulse_summary d%0d: high=%0d rise@%0d fall@%0d want 1 %0d %0d", dly(k), hi[k], ri[k], fi[k], dly(k) - 1, dly(k));
      end
    end
  endtask

  task automatic test_simultaneous();
    int rises[3], falls[3];
    a = 1'b1; b = 1'b0;
    for (int c = 0; c < 8; c++) step();
    for (int k = 0; k < 3; k++) begin rises[k] = 0; falls[k] = 0; end
    a = 1'b0; b = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (y[k] !== ye[k] || y_rise[k] !== re[k] || y_fall[k] !== fe[k]) begin
          n_fail++;
          $display("FAIL simul d%0d c%0d: y/r/f=%b%b%b want %b%b%b", dly(k), c, y[k], y_rise[k], y_fall[k], ye[k], re[k], fe[k]);
        end
        rises[k] += int'(y_rise[k]);
        falls[k] += int'(y_fall[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rises[k] != 1 || falls[k] != 0) begin
        n_fail++;
        $display("FAIL simul_summary d%0d: rises=%0d falls=%0d want 1 0", dly(k), rises[k], falls[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (y !== 3'b000 || y_rise !== 3'b000 || y_fall !== 3'b000) begin
          n_fail++;
          $display("FAIL rand_reset c%0d: y=%b rise=%b fall=%b want 000", c, y, y_rise, y_fall);
        end
        #1;
        rst = 1'b0;
      end
      step();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (y[k] !== ye[k] || y_rise[k] !== re[k] || y_fall[k] !== fe[k] || y_comb[k] !== (~a & b)) begin
          n_fail++;
          $display("FAIL rand d%0d c%0d: y/r/f/c=%b%b%b%b want %b%b%b%b", dly(k), c, y[k], y_rise[k], y_fall[k], y_comb[k], ye[k], re[k], fe[k], ~a & b);
        end
      end
    end
  endtask

`ifdef LAB3_Q2_RISE_COUNT_EN
  task automatic test_counter();
    rst = 1'b1; a = 1'b0; b = 1'b0;
    #1;
    model_reset();
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 6; c++) begin
        b = (c < 3);
        step();
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (y_cnt[k] !== 2'(cnt_e[k])) begin
            n_fail++;
            $display("FAIL cnt d%0d t%0d c%0d: y_cnt=%0d want %0d", dly(k), t, c, y_cnt[k], cnt_e[k] % 4);
          end
        end
      end
    end
    b = 1'b0;
    for (int c = 0; c < 6; c++) step();
    n_tests++;
    if (y_cnt !== {2'd1, 2'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL cnt_wrap: y_cnt=%h want 15", y_cnt);
    end
    b = 1'b1;
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (y_cnt !== '0) begin
      n_fail++;
      $display("FAIL cnt_reset: y_cnt=%h want 0", y_cnt);
    end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_truth_sweep();
    test_pulse();
    test_simultaneous();
    test_random();
`ifdef LAB3_Q2_RISE_COUNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
